alu_sequencer: RTL and testbench

Command-level controller for the ALU datapath (`alu_datapath`). It accepts one operation per valid/ready transaction (opcode plus two operands) and drives the datapath load strobes `store_a`, `store_b` and `start` in order. It then waits for `alu_done` under a timeout and returns the result on a valid/ready response channel. It sits between the bus/test host and the datapath and is the only block that drives the datapath control inputs.

---
 rtl/alu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-level controller for the ALU datapath.
// Takes one {opcode, a, b} command per handshake. Pulses store_a, store_b and
// start in that order, then waits a bounded number of cycles for alu_done.
// Returns the captured result, or a timeout error, on a valid/ready channel.
module alu_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_opcode,
   input  logic [DATA_WIDTH-1:0] cmd_a,
   input  logic [DATA_WIDTH-1:0] cmd_b,
   output logic [DATA_WIDTH-1:0] alu_data,
   output logic [1:0]            opcode_value,
   output logic                  store_a,
   output logic                  store_b,
   output logic                  start,
   input  logic                  alu_done,
   input  logic [DATA_WIDTH-1:0] result,
   input  logic                  overflow,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_overflow,
   output logic                  rsp_error,
   output logic                  busy,
   output logic [15:0]           op_count
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_A,
      ST_LOAD_B,
      ST_START,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;

   // The wait counter only ever needs to reach TIMEOUT-1.
   localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   state_t                state_reg, state_next;
   logic [1:0]            opcode_reg, opcode_next;
   logic [DATA_WIDTH-1:0] a_reg, a_next;
   logic [DATA_WIDTH-1:0] b_reg, b_next;
   logic [CW-1:0]         cnt_reg, cnt_next;
   logic [DATA_WIDTH-1:0] res_reg, res_next;
   logic                  ovf_reg, ovf_next;
   logic                  err_reg, err_next;
   logic [15:0]           op_count_reg, op_count_next;

   // Next-state, captured fields and all outputs are decoded from the current state.
   always_comb begin
      state_next    = state_reg;
      opcode_next   = opcode_reg;
      a_next        = a_reg;
      b_next        = b_reg;
      cnt_next      = cnt_reg;
      res_next      = res_reg;
      ovf_next      = ovf_reg;
      err_next      = err_reg;
      op_count_next = op_count_reg;
      cmd_ready     = 1'b0;
      store_a       = 1'b0;
      store_b       = 1'b0;
      start         = 1'b0;
      alu_data      = '0;
      opcode_value  = opcode_reg;
      rsp_valid     = 1'b0;
      busy          = 1'b1;

      case (state_reg)
         ST_IDLE: begin
            cmd_ready    = 1'b1;
            busy         = 1'b0;
            opcode_value = 2'b00;
            if (cmd_valid) begin
               opcode_next = cmd_opcode;
               a_next      = cmd_a;
               b_next      = cmd_b;
               state_next  = ST_LOAD_A;
            end
         end
         ST_LOAD_A: begin
            store_a    = 1'b1;
            alu_data   = a_reg;
            state_next = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            store_b    = 1'b1;
            alu_data   = b_reg;
            state_next = ST_START;
         end
         ST_START: begin
            start      = 1'b1;
            cnt_next   = '0;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_next = cnt_reg + CW'(1);
            // A completion in the last allowed cycle still counts as success.
            if (alu_done) begin
               res_next   = result;
               ovf_next   = (opcode_reg == OP_ADD || opcode_reg == OP_SUB) ? overflow : 1'b0;
               err_next   = 1'b0;
               state_next = ST_RESP;
            end else if (cnt_reg == CNT_LAST) begin
               res_next   = '0;
               ovf_next   = 1'b0;
               err_next   = 1'b1;
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = ST_IDLE;
               if (!err_reg) begin
                  op_count_next = op_count_reg + 16'd1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Command fields, wait counter, response fields and completed-op counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         opcode_reg   <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         cnt_reg      <= '0;
         res_reg      <= '0;
         ovf_reg      <= 1'b0;
         err_reg      <= 1'b0;
         op_count_reg <= '0;
      end else begin
         opcode_reg   <= opcode_next;
         a_reg        <= a_next;
         b_reg        <= b_next;
         cnt_reg      <= cnt_next;
         res_reg      <= res_next;
         ovf_reg      <= ovf_next;
         err_reg      <= err_next;
         op_count_reg <= op_count_next;
      end
   end

   assign rsp_result   = res_reg;
   assign rsp_overflow = ovf_reg;
   assign rsp_error    = err_reg;
   assign op_count     = op_count_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven, hand-written and randomized checks of
// alu_sequencer. The bench plays the role of the datapath. It chooses in which
// WAIT cycle alu_done arrives and what result/overflow it reports.
module tb_alu_sequencer;
   localparam int DW = 8;
   localparam int TO = 16;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_PAR  = 2'b10;
   localparam logic [1:0] OP_COMP = 2'b11;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_opcode;
   logic [DW-1:0] cmd_a;
   logic [DW-1:0] cmd_b;
   logic [DW-1:0] alu_data;
   logic [1:0]    opcode_value;
   logic          store_a;
   logic          store_b;
   logic          start;
   logic          alu_done;
   logic [DW-1:0] result;
   logic          overflow;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_result;
   logic          rsp_overflow;
   logic          rsp_error;
   logic          busy;
   logic [15:0]   op_count;

   always #5 clk = ~clk;

   alu_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_data(alu_data), .opcode_value(opcode_value),
      .store_a(store_a), .store_b(store_b), .start(start),
      .alu_done(alu_done), .result(result), .overflow(overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_error(rsp_error),
      .busy(busy), .op_count(op_count)
   );

   // wait_idx: WAIT cycle (0-based) in which the datapath raises alu_done;
   // values >= TO mean it never answers in time.
   typedef struct {
      logic [1:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      int            wait_idx;
      int            stall;
      logic [DW-1:0] dp_result;
      logic          dp_ovf;
      logic [DW-1:0] exp_result;
      logic          exp_ovf;
      logic          exp_err;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] count_model = 16'd0;
   vec_t        tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                               input int wait_idx, input int stall,
                               input logic [7:0] dp_result, input logic dp_ovf,
                               input logic [7:0] exp_result, input logic exp_ovf,
                               input logic exp_err);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.wait_idx = wait_idx; v.stall = stall;
      v.dp_result = dp_result; v.dp_ovf = dp_ovf;
      v.exp_result = exp_result; v.exp_ovf = exp_ovf; v.exp_err = exp_err;
      return v;
   endfunction

   // Reference: the datapath answer is returned if it arrives within TO WAIT
   // cycles; overflow only matters for arithmetic ops; otherwise an error.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (v.wait_idx >= 0 && v.wait_idx < TO) begin
         r.exp_result = v.dp_result;
         r.exp_ovf    = (v.op == OP_ADD || v.op == OP_SUB) ? v.dp_ovf : 1'b0;
         r.exp_err    = 1'b0;
      end else begin
         r.exp_result = '0;
         r.exp_ovf    = 1'b0;
         r.exp_err    = 1'b1;
      end
      return r;
   endfunction

   task automatic chk_reset_state(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_strobes"}, {store_a, store_b, start}, 3'b000);
      chk({tag, "_alu_data"}, alu_data, 0);
      chk({tag, "_opcode_value"}, opcode_value, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_result"}, rsp_result, 0);
      chk({tag, "_rsp_overflow"}, rsp_overflow, 0);
      chk({tag, "_rsp_error"}, rsp_error, 0);
      chk({tag, "_op_count"}, op_count, 0);
   endtask

   // One full transaction; all sampling and driving happens on the falling edge.
   task automatic run_op(input vec_t v);
      int lat;
      int exp_lat;
      bit seen;
      exp_lat = v.exp_err ? TO : v.wait_idx + 1;
      @(negedge clk);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_opcode_value", opcode_value, 0);
      cmd_valid = 1'b1; cmd_opcode = v.op; cmd_a = v.a; cmd_b = v.b;
      alu_done = 1'b1; result = 8'($urandom); overflow = 1'b1;
      @(negedge clk);  // LOAD_A
      cmd_valid = 1'b0; cmd_opcode = ~v.op; cmd_a = ~v.a; cmd_b = ~v.b;
      chk("la_strobes", {store_a, store_b, start}, 3'b100);
      chk("la_alu_data", alu_data, v.a);
      chk("la_opcode_value", opcode_value, v.op);
      chk("la_cmd_ready", cmd_ready, 0);
      @(negedge clk);  // LOAD_B
      chk("lb_strobes", {store_a, store_b, start}, 3'b010);
      chk("lb_alu_data", alu_data, v.b);
      @(negedge clk);  // START
      chk("st_strobes", {store_a, store_b, start}, 3'b001);
      chk("st_alu_data", alu_data, 0);
      lat = 0; seen = 1'b0;
      for (int j = 0; j <= TO + 4; j++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = j; seen = 1'b1;
            break;
         end
         chk("wait_strobes", {store_a, store_b, start}, 3'b000);
         chk("wait_alu_data", alu_data, 0);
         rsp_ready = 1'($urandom_range(0, 1));
         alu_done  = (j == v.wait_idx);
         result    = (j == v.wait_idx) ? v.dp_result : 8'($urandom);
         overflow  = (j == v.wait_idx) ? v.dp_ovf : 1'($urandom_range(0, 1));
      end
      if (!seen) begin
         chk("rsp_within_bound", 0, 1);
         reset = 1'b1; @(negedge clk); reset = 1'b0;
         count_model = 16'd0;
         return;
      end
      chk("latency", lat, exp_lat);
      // Datapath keeps chattering during RESP; the response must not change.
      alu_done = 1'b1; result = ~v.dp_result; overflow = ~v.dp_ovf;
      for (int s = 0; s <= v.stall; s++) begin
         if (s > 0) @(negedge clk);
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_result", rsp_result, v.exp_result);
         chk("rsp_overflow", rsp_overflow, v.exp_ovf);
         chk("rsp_error", rsp_error, v.exp_err);
         chk("rsp_cmd_ready", cmd_ready, 0);
         chk("rsp_busy", busy, 1);
         chk("rsp_opcode_value", opcode_value, v.op);
         chk("rsp_op_count_hold", op_count, count_model);
         rsp_ready = (s == v.stall);
      end
      @(negedge clk);
      rsp_ready = 1'b0; alu_done = 1'b0;
      if (!v.exp_err) count_model = count_model + 16'd1;
      chk("post_rsp_valid", rsp_valid, 0);
      chk("post_cmd_ready", cmd_ready, 1);
      chk("post_busy", busy, 0);
      chk("post_op_count", op_count, count_model);
      $display("op=%0d a=%02h b=%02h wait=%0d stall=%0d -> result=%02h ovf=%0b err=%0b lat=%0d op_count=%04h",
               v.op, v.a, v.b, v.wait_idx, v.stall, rsp_result, v.exp_ovf, v.exp_err, lat, op_count);
   endtask

   // Strobes must never overlap outside reset.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         total++;
         if (!$onehot0({store_a, store_b, start})) begin
            bad++;
            $display("FAIL strobe_onehot: got %03b required at most one set", {store_a, store_b, start});
         end
      end
   end

   initial begin
      //          op       a      b      wait stall dp     ovf   exp    ovf   err
      tbl[0] = mk(OP_ADD,  8'h7F, 8'h01,  2,  0,    8'h80, 1'b1, 8'h80, 1'b1, 1'b0);
      tbl[1] = mk(OP_SUB,  8'h05, 8'h03,  0,  4,    8'h02, 1'b0, 8'h02, 1'b0, 1'b0);
      tbl[2] = mk(OP_PAR,  8'h05, 8'h03,  3,  0,    8'h01, 1'b1, 8'h01, 1'b0, 1'b0);
      tbl[3] = mk(OP_COMP, 8'h11, 8'h22,  1,  1,    8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0);
      tbl[4] = mk(OP_ADD,  8'h01, 8'h02, 99,  1,    8'h03, 1'b0, 8'h00, 1'b0, 1'b1);
      tbl[5] = mk(OP_ADD,  8'h10, 8'h20, 15,  0,    8'h30, 1'b1, 8'h30, 1'b1, 1'b0);
      tbl[6] = mk(OP_SUB,  8'h80, 8'h01, 16,  0,    8'h7F, 1'b1, 8'h00, 1'b0, 1'b1);
      tbl[7] = mk(OP_SUB,  8'h80, 8'h01, 14,  2,    8'h7F, 1'b1, 8'h7F, 1'b1, 1'b0);

      reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
      alu_done = 1'b0; result = '0; overflow = 1'b0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_reset_state("reset");

      for (int i = 0; i < 8; i++) run_op(tbl[i]);

      // Reset during LOAD_B aborts the command with no response.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_a = 8'h33; cmd_b = 8'h44;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("abort_in_load_b", store_b, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      count_model = 16'd0;
      chk_reset_state("abort");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", rsp_valid, 0);
      end
      run_op(mk(OP_COMP, 8'h5A, 8'hA5, 4, 1, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0));

      // Randomized traffic against the reference model.
      for (int i = 0; i < 30; i++) begin
         vec_t r;
         r.op        = 2'($urandom_range(0, 3));
         r.a         = 8'($urandom);
         r.b         = 8'($urandom);
         r.wait_idx  = $urandom_range(0, TO + 2);
         r.stall     = $urandom_range(0, 3);
         r.dp_result = 8'($urandom);
         r.dp_ovf    = 1'($urandom_range(0, 1));
         run_op(model(r));
      end

      // op_count wrap: preload FFFF, one successful op must give 0000.
      @(negedge clk);
      force dut.op_count_reg = 16'hFFFF;
      @(negedge clk);
      release dut.op_count_reg;
      count_model = 16'hFFFF;
      chk("wrap_preload", op_count, 16'hFFFF);
      run_op(mk(OP_ADD, 8'h01, 8'h01, 0, 0, 8'h02, 1'b0, 8'h02, 1'b0, 1'b0));
      chk("wrap_zero", op_count, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
